// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : shift_pipe
// Description : Pipelined logarithmic barrel shifter / rotator.
//               SRL, SRA, SLL, ROR and ROL on a WIDTH-bit operand, with the
//               SHW = log2(WIDTH) shift levels spread over STAGES registers.
//               Left operations are done by bit-reversing on entry and on
//               exit, so the core only ever shifts right.
//               Flow control is valid/ready with a global stall, plus a
//               flush that empties the pipe.
// Ports       : i_clk, i_rst (sync, active-high)
//               i_valid / o_ready          : input handshake
//               i_data, i_shamt, i_mode    : operand, amount, operation
//                                            (000 SRL, 001 SRA, 010 SLL,
//                                             011 ROR, 100 ROL, else -> 0)
//               i_tag                      : sideband returned with result
//               i_flush                    : drop everything in flight
//               o_valid / i_ready          : output handshake
//               o_data, o_tag              : result and its tag
// Revision    : 1.0 - initial release
// ============================================================================
module shift_pipe #(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int TAG_W  = 5,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_shamt,
  input  logic [2:0]       i_mode,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [TAG_W-1:0] o_tag
);

  localparam logic [2:0] c_mode_srl = 3'b000;
  localparam logic [2:0] c_mode_sra = 3'b001;
  localparam logic [2:0] c_mode_sll = 3'b010;
  localparam logic [2:0] c_mode_ror = 3'b011;
  localparam logic [2:0] c_mode_rol = 3'b100;
  localparam int         c_last     = STAGES - 1;

  if ((WIDTH < 8) || (WIDTH > 64) || ((1 << SHW) != WIDTH) ||
      (STAGES < 1) || (STAGES > SHW)) begin : g_bad_params
    $error("shift_pipe: unsupported WIDTH/STAGES combination");
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  function automatic logic is_left(input logic [2:0] mode);
    return (mode == c_mode_sll) || (mode == c_mode_rol);
  endfunction

  function automatic logic is_rotate(input logic [2:0] mode);
    return (mode == c_mode_ror) || (mode == c_mode_rol);
  endfunction

  function automatic logic is_reserved(input logic [2:0] mode);
    return mode > c_mode_rol;
  endfunction

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = x[WIDTH-1-i];
    end
    return r;
  endfunction

  // One right-shift level by amt (amt < WIDTH). Vacated top bits take either
  // the bits that fell off the bottom (rotate) or the fill bit.
  function automatic logic [WIDTH-1:0] shift_level(input logic [WIDTH-1:0] x,
                                                   input int               amt,
                                                   input logic             rotate,
                                                   input logic             fill);
    logic [WIDTH-1:0] top_mask;
    top_mask = ~({WIDTH{1'b1}} >> amt);
    if (rotate) begin
      return (x >> amt) | (x << (WIDTH - amt));
    end
    return (x >> amt) | (fill ? top_mask : '0);
  endfunction

  // Combinational part of one register stage: the levels mapped onto this
  // stage, then (last stage only) the exit transform.
  function automatic logic [WIDTH-1:0] stage_compute(input logic [WIDTH-1:0] x,
                                                     input logic [SHW-1:0]   shamt,
                                                     input logic [2:0]       mode,
                                                     input logic             sign,
                                                     input int               stage);
    logic [WIDTH-1:0] y;
    y = x;
    for (int j = 0; j < SHW; j++) begin
      if (((j * STAGES) / SHW == stage) && shamt[j]) begin
        y = shift_level(y, 1 << j, is_rotate(mode), (mode == c_mode_sra) && sign);
      end
    end
    if (stage == c_last) begin
      if (is_reserved(mode)) begin
        y = '0;
      end else if (is_left(mode)) begin
        y = bit_rev(y);
      end
    end
    return y;
  endfunction

  // --------------------------------------------------------------------------
  // Stage registers; the last stage's data/tag are the output registers
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]  r_data_q  [STAGES];
  logic [SHW-1:0]    r_shamt_q [STAGES];
  logic [2:0]        r_mode_q  [STAGES];
  logic [TAG_W-1:0]  r_tag_q   [STAGES];
  logic              r_sign_q  [STAGES];
  logic [STAGES-1:0] r_valid_q;

  logic [WIDTH-1:0]  w_data_d  [STAGES];
  logic [SHW-1:0]    w_shamt_d [STAGES];
  logic [2:0]        w_mode_d  [STAGES];
  logic [TAG_W-1:0]  w_tag_d   [STAGES];
  logic              w_sign_d  [STAGES];
  logic [STAGES-1:0] w_valid_d;
  logic              w_advance;

  // Global stall: the whole pipe moves only when the output slot frees up.
  assign o_valid   = r_valid_q[c_last];
  assign o_ready   = !(o_valid && !i_ready);
  assign w_advance = o_ready;
  assign o_data    = r_data_q[c_last];
  assign o_tag     = r_tag_q[c_last];

  always_comb begin
    // Entry stage: left operations are mirrored so the core shifts right.
    // The sign bit is taken from the untouched operand and travels with it.
    w_data_d[0]  = stage_compute(is_left(i_mode) ? bit_rev(i_data) : i_data,
                                 i_shamt, i_mode, i_data[WIDTH-1], 0);
    w_shamt_d[0] = i_shamt;
    w_mode_d[0]  = i_mode;
    w_tag_d[0]   = i_tag;
    w_sign_d[0]  = i_data[WIDTH-1];
    w_valid_d[0] = i_valid;
    for (int s = 1; s < STAGES; s++) begin
      w_data_d[s]  = stage_compute(r_data_q[s-1], r_shamt_q[s-1], r_mode_q[s-1],
                                   r_sign_q[s-1], s);
      w_shamt_d[s] = r_shamt_q[s-1];
      w_mode_d[s]  = r_mode_q[s-1];
      w_tag_d[s]   = r_tag_q[s-1];
      w_sign_d[s]  = r_sign_q[s-1];
      w_valid_d[s] = r_valid_q[s-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_q        <= '0;
      r_data_q[c_last] <= '0;
      r_tag_q[c_last]  <= '0;
    end else begin
      // Flush wins over stall; an input offered with the flush is dropped.
      if (i_flush) begin
        r_valid_q <= '0;
      end else if (w_advance) begin
        r_valid_q <= w_valid_d;
      end
      if (w_advance) begin
        for (int s = 0; s < STAGES; s++) begin
          r_shamt_q[s] <= w_shamt_d[s];
          r_mode_q[s]  <= w_mode_d[s];
          r_sign_q[s]  <= w_sign_d[s];
        end
        for (int s = 0; s < c_last; s++) begin
          r_data_q[s] <= w_data_d[s];
          r_tag_q[s]  <= w_tag_d[s];
        end
        // Output registers change only when a real result moves in.
        if (w_valid_d[c_last] && !i_flush) begin
          r_data_q[c_last] <= w_data_d[c_last];
          r_tag_q[c_last]  <= w_tag_d[c_last];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_pipe
// Description : Self-checking bench for shift_pipe. Directed tests on a
//               32-bit / 2-stage instance, plus a random sweep over
//               WIDTH {8,32,64} x STAGES {1,log2(WIDTH)} against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_pipe;

  localparam int NCFG = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // ---------------- main 32-bit / 2-stage instance ----------------
  logic        m_valid, m_oready, m_flush, m_ovalid, m_iready;
  logic [31:0] m_data, m_odata;
  logic [4:0]  m_shamt;
  logic [2:0]  m_mode;
  logic [4:0]  m_tag, m_otag;

  shift_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(m_valid), .o_ready(m_oready),
    .i_data(m_data), .i_shamt(m_shamt), .i_mode(m_mode), .i_tag(m_tag),
    .i_flush(m_flush), .o_valid(m_ovalid), .i_ready(m_iready),
    .o_data(m_odata), .o_tag(m_otag)
  );

  // ---------------- sweep instances ----------------
  logic        sw_valid, sw_ready;
  logic [63:0] sw_data;
  logic [5:0]  sw_shamt;
  logic [2:0]  sw_mode;
  logic [4:0]  sw_tag;
  logic        sw_oready [NCFG];
  logic        sw_ovalid [NCFG];
  logic [63:0] sw_odata  [NCFG];
  logic [4:0]  sw_otag   [NCFG];

  function automatic int cfg_w(input int k);
    return (k < 2) ? 8 : ((k < 4) ? 32 : 64);
  endfunction

  function automatic int cfg_s(input int k);
    return (k % 2 == 0) ? 1 : $clog2(cfg_w(k));
  endfunction

  for (genvar k = 0; k < NCFG; k++) begin : g_sweep
    localparam int W  = (k < 2) ? 8 : ((k < 4) ? 32 : 64);
    localparam int SH = $clog2(W);
    localparam int S  = (k % 2 == 0) ? 1 : SH;
    logic [W-1:0] od;
    logic [4:0]   ot;
    logic         ov, ordy;
    shift_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(5)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_valid(sw_valid), .o_ready(ordy),
      .i_data(sw_data[W-1:0]), .i_shamt(sw_shamt[SH-1:0]), .i_mode(sw_mode),
      .i_tag(sw_tag), .i_flush(1'b0), .o_valid(ov), .i_ready(sw_ready),
      .o_data(od), .o_tag(ot)
    );
    assign sw_odata[k]  = 64'(od);
    assign sw_otag[k]   = ot;
    assign sw_ovalid[k] = ov;
    assign sw_oready[k] = ordy;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", name, obs, exp);
    end
  endtask

  // Reference: plain shift/rotate arithmetic on a w-bit value.
  function automatic logic [63:0] ref_shift(input logic [63:0] d_in, input int s,
                                            input logic [2:0] mode, input int w);
    logic [63:0]        mask, d, r;
    logic signed [63:0] sd;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    d    = d_in & mask;
    case (mode)
      3'd0: r = d >> s;
      3'd1: begin
        sd = d << (64 - w);
        sd = sd >>> (64 - w);
        r  = sd >>> s;
      end
      3'd2: r = d << s;
      3'd3: r = (d >> s) | (d << (w - s));
      3'd4: r = (d << s) | (d >> (w - s));
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation into an empty pipe with i_ready = 1; checks latency.
  task automatic single_op(input string name, input logic [31:0] d, input logic [4:0] sh,
                           input logic [2:0] mode, input logic [4:0] tag,
                           input logic [31:0] exp);
    m_valid = 1'b1; m_data = d; m_shamt = sh; m_mode = mode; m_tag = tag;
    check({name, "_ready"}, 64'(m_oready), 64'd1);
    tick();
    m_valid = 1'b0;
    check({name, "_early"}, 64'(m_ovalid), 64'd0);
    tick();
    check({name, "_valid"}, 64'(m_ovalid), 64'd1);
    check({name, "_data"}, 64'(m_odata), 64'(exp));
    check({name, "_tag"}, 64'(m_otag), 64'(tag));
    tick();
    check({name, "_gone"}, 64'(m_ovalid), 64'd0);
  endtask

  logic [31:0] exp_data_q [$];
  logic [4:0]  exp_tag_q  [$];
  logic [63:0] sb_data [NCFG][16];
  logic [4:0]  sb_tag  [NCFG][16];
  int          sb_cyc  [NCFG][16];
  int          sb_wr   [NCFG];
  int          sb_rd   [NCFG];

  initial begin
    int issued, rcvd, stall_left, idx, w;
    bit stall_done, got4;

    rst = 1'b1;
    m_valid = 0; m_data = 0; m_shamt = 0; m_mode = 0; m_tag = 0; m_flush = 0; m_iready = 1;
    sw_valid = 0; sw_data = 0; sw_shamt = 0; sw_mode = 0; sw_tag = 0; sw_ready = 1;
    for (int k = 0; k < NCFG; k++) begin sb_wr[k] = 0; sb_rd[k] = 0; end
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_valid", 64'(m_ovalid), 64'd0);
    check("rst_data", 64'(m_odata), 64'd0);
    check("rst_tag", 64'(m_otag), 64'd0);
    check("rst_ready", 64'(m_oready), 64'd1);
    for (int k = 0; k < NCFG; k++) check($sformatf("rst_sw%0d_valid", k), 64'(sw_ovalid[k]), 64'd0);

    // Basic modes
    single_op("srl", 32'h8000_00F1, 5'd4, 3'b000, 5'd1, 32'h0800_000F);
    single_op("sra", 32'h8000_00F1, 5'd4, 3'b001, 5'd2, 32'hF800_000F);
    single_op("sll", 32'h8000_00F1, 5'd4, 3'b010, 5'd3, 32'h0000_0F10);
    single_op("ror", 32'h8000_00F1, 5'd4, 3'b011, 5'd4, 32'h1800_000F);
    single_op("rol", 32'h8000_00F1, 5'd4, 3'b100, 5'd5, 32'h0000_0F18);

    // Boundary amounts
    single_op("srl31", 32'hFFFF_FFFF, 5'd31, 3'b000, 5'd6, 32'h0000_0001);
    single_op("sra31", 32'hFFFF_FFFF, 5'd31, 3'b001, 5'd7, 32'hFFFF_FFFF);
    for (int md = 0; md < 5; md++)
      single_op($sformatf("sh0_m%0d", md), 32'hFFFF_FFFF, 5'd0, 3'(md), 5'(md + 8), 32'hFFFF_FFFF);
    single_op("rsvd5", 32'hFFFF_FFFF, 5'd3, 3'b101, 5'd20, 32'h0000_0000);

    // Back-to-back stream with a 3-cycle downstream stall
    issued = 0; rcvd = 0; stall_left = 0; stall_done = 0;
    for (int c = 0; c < 60 && rcvd < 8; c++) begin
      if (!stall_done && m_ovalid) begin stall_left = 3; stall_done = 1; end
      m_iready = (stall_left == 0);
      if (issued < 8) begin
        m_valid = 1'b1; m_data = $urandom; m_shamt = 5'($urandom_range(0, 31));
        m_mode = 3'($urandom_range(0, 4)); m_tag = 5'(issued);
      end else begin
        m_valid = 1'b0;
      end
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall_ready", 64'(m_oready), 64'd0);
        check("stall_valid", 64'(m_ovalid), 64'd1);
        if (exp_data_q.size() > 0) begin
          check("stall_data", 64'(m_odata), 64'(exp_data_q[0]));
          check("stall_tag", 64'(m_otag), 64'(exp_tag_q[0]));
        end
        stall_left--;
      end
      if (m_ovalid && m_iready) begin
        if (exp_data_q.size() == 0) begin
          check("stream_extra", 64'd1, 64'd0);
        end else begin
          check("stream_data", 64'(m_odata), 64'(exp_data_q.pop_front()));
          check("stream_tag", 64'(m_otag), 64'(exp_tag_q.pop_front()));
          rcvd++;
        end
      end
      if (m_valid && m_oready) begin
        exp_data_q.push_back(32'(ref_shift(64'(m_data), int'(m_shamt), m_mode, 32)));
        exp_tag_q.push_back(m_tag);
        issued++;
      end
      @(posedge clk); #1;
    end
    m_valid = 1'b0; m_iready = 1'b1;
    check("stream_count", 64'(rcvd), 64'd8);
    check("stream_stalled", 64'(stall_done), 64'd1);
    tick(); tick();
    check("stream_nodup", 64'(m_ovalid), 64'd0);

    // Flush: tags 1..3 issued while downstream is stalled, flush with tag 3
    m_iready = 1'b0;
    m_valid = 1'b1; m_data = 32'h1111_1111; m_shamt = 5'd1; m_mode = 3'b000; m_tag = 5'd1;
    tick();
    m_tag = 5'd2;
    tick();
    m_tag = 5'd3; m_flush = 1'b1;
    tick();
    m_flush = 1'b0;
    check("flush_valid", 64'(m_ovalid), 64'd0);
    check("flush_ready", 64'(m_oready), 64'd1);
    m_iready = 1'b1;
    m_data = 32'h0000_00F0; m_shamt = 5'd4; m_mode = 3'b000; m_tag = 5'd4;
    got4 = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_ovalid && m_iready) begin
        if (m_otag >= 5'd1 && m_otag <= 5'd3) check("flush_leak_tag", 64'(m_otag), 64'd4);
        if (m_otag == 5'd4) begin
          check("flush_t4_data", 64'(m_odata), 64'h0000_000F);
          got4 = 1;
        end
      end
      @(posedge clk); #1;
      m_valid = 1'b0;
    end
    check("flush_t4_seen", 64'(got4), 64'd1);

    // Reset with two operations in flight
    m_iready = 1'b0;
    m_valid = 1'b1; m_data = 32'h1234_5678; m_shamt = 5'd0; m_mode = 3'b000; m_tag = 5'd9;
    tick();
    m_data = 32'h0F0F_0F0F; m_shamt = 5'd1; m_mode = 3'b010; m_tag = 5'd10;
    tick();
    m_valid = 1'b0;
    check("prerst_valid", 64'(m_ovalid), 64'd1);
    check("prerst_tag", 64'(m_otag), 64'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 64'(m_ovalid), 64'd0);
    check("midrst_data", 64'(m_odata), 64'd0);
    check("midrst_tag", 64'(m_otag), 64'd0);
    check("midrst_ready", 64'(m_oready), 64'd1);
    m_iready = 1'b1;

    // Parameter sweep: phase 1 free-flowing (latency checked),
    // phase 2 random back-pressure, then drain.
    for (int c = 0; c < 600; c++) begin
      sw_valid = (c < 560) && ($urandom_range(0, 3) != 0);
      sw_ready = (c < 200 || c >= 560) ? 1'b1 : ($urandom_range(0, 2) != 0);
      sw_data  = {$urandom, $urandom};
      sw_shamt = 6'($urandom_range(0, 63));
      sw_mode  = 3'($urandom_range(0, 7));
      sw_tag   = 5'($urandom_range(0, 31));
      @(negedge clk);
      for (int k = 0; k < NCFG; k++) begin
        w = cfg_w(k);
        check($sformatf("sw%0d_oready", k), 64'(sw_oready[k]), 64'(!(sw_ovalid[k] && !sw_ready)));
        if (sw_ovalid[k] && sw_ready) begin
          if (sb_wr[k] == sb_rd[k]) begin
            check($sformatf("sw%0d_spurious", k), 64'd1, 64'd0);
          end else begin
            idx = sb_rd[k] % 16;
            check($sformatf("sw%0d_data", k), sw_odata[k], sb_data[k][idx]);
            check($sformatf("sw%0d_tag", k), 64'(sw_otag[k]), 64'(sb_tag[k][idx]));
            if (c < 200)
              check($sformatf("sw%0d_latency", k), 64'(c - sb_cyc[k][idx]), 64'(cfg_s(k)));
            sb_rd[k]++;
          end
        end
        if (sw_valid && sw_oready[k]) begin
          idx = sb_wr[k] % 16;
          sb_data[k][idx] = ref_shift(sw_data, int'(sw_shamt) % w, sw_mode, w);
          sb_tag[k][idx]  = sw_tag;
          sb_cyc[k][idx]  = c;
          sb_wr[k]++;
        end
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("sw%0d_drained", k), 64'(sb_wr[k] - sb_rd[k]), 64'd0);
      check($sformatf("sw%0d_idle", k), 64'(sw_ovalid[k]), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/shift_pipe.md
# shift_pipe

Parametrised, pipelined successor to the single-cycle 32-bit combinational shifter. Shifts or rotates a WIDTH-bit operand by a log2(WIDTH)-bit amount over STAGES register stages, with valid/ready flow control, a tag carried alongside each operation, and a flush for pipeline redirect. It sits in the execute stage next to the ALU and serves SLL/SRL/SRA plus the rotate extensions.

## Interface
- WIDTH, 32: operand width; power of two, 8 to 64.
- STAGES, 2: register stages, 1 to SHW, where SHW = $clog2(WIDTH).
- TAG_W, 5: width of the sideband tag, for example the destination register index.
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  reset; synchronous and active-high.
- i_valid  in  1  input operation present.
- o_ready  out  1  block can accept the input this cycle.
- i_data  in  WIDTH  operand.
- i_shamt  in  SHW  shift amount, unsigned.
- i_mode  in  3  operation: 000 SRL, 001 SRA, 010 SLL, 011 ROR, 100 ROL; 101 to 111 are reserved.
- i_tag  in  TAG_W  sideband, returned unchanged with the result.
- i_flush  in  1  discard every operation in flight.
- o_valid  out  1  result present.
- i_ready  in  1  downstream consumer accepts the result.
- o_data  out  WIDTH  result.
- o_tag  out  TAG_W  tag of the result.

## Operation
- Transfer rules:
  - An input transfer occurs when i_valid && o_ready.
  - An output transfer occurs when o_valid && i_ready.
- Datapath:
  - Logarithmic barrel shifter with SHW levels. Level j shifts by 2^j when i_shamt[j] = 1.
  - Level j sits in register stage floor(j*STAGES/SHW). Each stage registers its partial result, its own copies of shamt, mode and tag, and a valid bit.
- Left operations (SLL, ROL):
  - The operand is bit-reversed on entry and the result is bit-reversed on exit.
  - The core therefore implements only right shifts.
- Fill bit for each right-shift level:
  - SRL and SLL: 0.
  - SRA: the original i_data[WIDTH-1], carried down the pipe.
  - ROR and ROL: the bits shifted out, so the operation wraps around.
- Reserved modes:
  - The operation is accepted and flows through the pipe normally.
  - o_data is 0 and o_tag is passed through.
- shamt = 0 returns i_data unchanged in every defined mode.
- Stall:
  - o_ready = !(o_valid && !i_ready).
  - When stalled, every stage holds its contents.
  - Bubbles are not collapsed: a stalled pipe with empty middle stages stays stalled until the output transfer.
- Flush:
  - When i_flush = 1, every valid bit is 0 on the next edge.
  - An input offered in the same cycle as the flush is dropped, even if o_ready was 1.
  - Flush overrides stall.
- Reset: all valid bits, o_data and o_tag are 0 on the edge following i_rst = 1. Reset overrides flush and the handshake.
- Data registers of invalid stages are don't-care internally. The o_data and o_tag registers load only on a valid advance.

## Timing
- Latency: a result accepted at edge N is presented with o_valid = 1 after edge N+STAGES-1.
  - STAGES = 1: the output register captures the result at the accept edge, so o_valid is 1 in the cycle after the accept.
- Throughput: one operation per cycle while i_ready = 1.
- o_ready is combinational from o_valid and i_ready only. It has no path from i_valid or i_flush.
- When i_ready is 0 with o_valid = 1:
  - o_data and o_tag hold stable.
  - o_valid does not drop, except on flush or reset.
- An output transfer and a new input transfer may occur in the same cycle. Pipe occupancy is then unchanged.
- Reset or flush mid-operation: the pipe is empty from the following cycle and o_ready = 1.

## Test plan
- Basic modes (WIDTH=32, STAGES=2, i_data=0x8000_00F1, shamt=4):
  - SRL -> 0x0800_000F.
  - SRA -> 0xF800_000F.
  - SLL -> 0x0000_0F10.
  - ROR -> 0x1800_000F.
  - ROL -> 0x0000_0F18.
  - Each arrives 2 cycles after its accept, with the matching tag.
- Boundary amounts (i_data=0xFFFF_FFFF):
  - SRL shamt=31 -> 0x0000_0001.
  - SRA shamt=31 -> 0xFFFF_FFFF.
  - shamt=0 in every mode -> 0xFFFF_FFFF.
  - Mode 101 -> 0x0000_0000 with o_valid = 1.
- Back-to-back and stall:
  - Stream 8 operations with tags 0 to 7.
  - Hold i_ready = 0 for 3 cycles after the first result appears.
  - Required: o_data and o_tag stable, o_ready = 0, no loss or duplication, results in order 0 to 7.
- Flush:
  - Issue tags 1, 2 and 3 in consecutive cycles and assert i_flush together with tag 3.
  - Required: no result with tag 1, 2 or 3 is ever seen, and o_valid = 0 in the next cycle.
  - Tag 4, issued 1 cycle later, returns normally.
- Reset mid-stream: assert i_rst for 1 cycle with 2 operations in flight -> o_valid = 0, o_data = 0, o_tag = 0, o_ready = 1 on the next cycle.
- Parameter sweep: WIDTH in {8, 32, 64} × STAGES in {1, SHW} against a behavioural model.
  - Random data, shamt, mode and i_ready.
  - Required: latency equals STAGES in every configuration.
